// File: rtl/ddr4_cal_seq_pkg.sv
// Shared definitions for the DDR4 calibration ROM sequencer: instruction codes,
// ROM word field layout and FSM state encoding.
package ddr4_cal_seq_pkg;

    localparam logic [7:0] INSTR_END   = 8'h00;
    localparam logic [7:0] INSTR_WRITE = 8'h01;
    localparam logic [7:0] INSTR_READ  = 8'h02;
    localparam logic [7:0] INSTR_WAIT  = 8'h03;
    localparam logic [7:0] INSTR_JUMP  = 8'h04;

    localparam int BL_MSB    = 31;
    localparam int BL_LSB    = 24;
    localparam int INSTR_MSB = 23;
    localparam int INSTR_LSB = 16;
    localparam int ADDR_MSB  = 15;
    localparam int ADDR_LSB  = 0;

    typedef struct packed {
        logic [BL_MSB-BL_LSB:0]       burst_len;
        logic [INSTR_MSB-INSTR_LSB:0] instr;
        logic [ADDR_MSB-ADDR_LSB:0]   addr;
    } cal_entry_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_DELAY,
        S_NEXT,
        S_DONE,
        S_ERR
    } state_t;

endpackage

// File: rtl/ddr4_cal_rom_sequencer.sv
// Walks the calibration config ROM and turns each entry into a valid/ready
// command stream (WRITE/READ bursts), with WAIT, JUMP and END control entries.
module ddr4_cal_rom_sequencer
    import ddr4_cal_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [DATA_WIDTH-1:0] rom_data_i,
    output logic                  cmd_valid_o,
    input  logic                  cmd_ready_i,
    output logic [7:0]            cmd_instr_o,
    output logic [15:0]           cmd_addr_o,
    output logic [7:0]            cmd_beat_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [ADDR_WIDTH-1:0] pc_o
);

    localparam logic [ADDR_WIDTH-1:0] LAST_PC = ADDR_WIDTH'(DEPTH - 1);

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic                  cmd_valid_q;
    logic [7:0]            cmd_instr_q;
    logic [15:0]           cmd_addr_q;
    logic [7:0]            cmd_beat_q;
    logic [7:0]            last_beat_q;
    logic [15:0]           dly_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;
    cal_entry_t            ent;

    assign ent = cal_entry_t'(rom_data_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            cmd_valid_q <= 1'b0;
            cmd_instr_q <= '0;
            cmd_addr_q  <= '0;
            cmd_beat_q  <= '0;
            last_beat_q <= '0;
            dly_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        pc_q    <= '0;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: state_q <= S_DECODE;
                S_DECODE: begin
                    cmd_beat_q <= '0;
                    case (ent.instr)
                        INSTR_WRITE, INSTR_READ: begin
                            cmd_valid_q <= 1'b1;
                            cmd_instr_q <= ent.instr;
                            cmd_addr_q  <= ent.addr;
                            // A zero burst length still issues a single beat.
                            last_beat_q <= (ent.burst_len == 8'd0) ? 8'd0 : ent.burst_len - 8'd1;
                            state_q     <= S_ISSUE;
                        end
                        INSTR_WAIT: begin
                            dly_q   <= ent.addr;
                            state_q <= (ent.addr == 16'd0) ? S_NEXT : S_DELAY;
                        end
                        INSTR_JUMP: begin
                            pc_q    <= ent.addr[ADDR_WIDTH-1:0];
                            state_q <= S_FETCH;
                        end
                        INSTR_END: state_q <= S_DONE;
                        default:   state_q <= S_ERR;
                    endcase
                end
                S_ISSUE: begin
                    if (cmd_ready_i) begin
                        if (cmd_beat_q == last_beat_q) begin
                            cmd_valid_q <= 1'b0;
                            state_q     <= S_NEXT;
                        end else begin
                            cmd_beat_q <= cmd_beat_q + 8'd1;
                            cmd_addr_q <= cmd_addr_q + 16'd1;
                        end
                    end
                end
                S_DELAY: begin
                    if (dly_q == 16'd1) begin
                        state_q <= S_NEXT;
                    end else begin
                        dly_q <= dly_q - 16'd1;
                    end
                end
                S_NEXT: begin
                    // Falling off the last entry without an END is a program error.
                    if (pc_q == LAST_PC) begin
                        state_q <= S_ERR;
                    end else begin
                        pc_q    <= pc_q + 1'b1;
                        state_q <= S_FETCH;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                S_ERR: begin
                    busy_q  <= 1'b0;
                    err_q   <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rom_addr_o  = pc_q;
    assign pc_o        = pc_q;
    assign cmd_valid_o = cmd_valid_q;
    assign cmd_instr_o = cmd_instr_q;
    assign cmd_addr_o  = cmd_addr_q;
    assign cmd_beat_o  = cmd_beat_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule
